// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a head/skid register pair. It forwards a control bundle,
// scalar operands and vector operands, and it has flush and a saturating stall counter.
module pipe_stage_elastic #(
   parameter int N  = 32,
   parameter int V  = 20,
   parameter int L  = 8,
   parameter int CW = 16,
   parameter int SW = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [CW-1:0]             ctrl_i,
   input  logic [N-1:0]              s1_i,
   input  logic [N-1:0]              s2_i,
   input  logic [V-1:0][L-1:0]       v1_i,
   input  logic [V-1:0][L-1:0]       v2_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [CW-1:0]             ctrl_o,
   output logic [N-1:0]              s1_o,
   output logic [N-1:0]              s2_o,
   output logic [V-1:0][L-1:0]       v1_o,
   output logic [V-1:0][L-1:0]       v2_o,
   output logic [1:0]                occupancy_o,
   output logic [SW-1:0]             stall_cnt_o
);

   localparam int PW = CW + 2 * N + 2 * V * L;

   // The FSM state is the entry count. occupancy_o exposes it directly.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] head_q;
   logic [PW-1:0] skid_q;
   logic [PW-1:0] in_pay;
   logic [CW-1:0] head_ctrl;
   logic          in_fire;
   logic          out_fire;
   logic          stalled;

   // Handshake: a transfer happens on an edge where valid and ready are both high.
   // in_ready_o depends only on the registered state. It never looks at out_ready_i.
   assign in_ready_o  = (state != ST_TWO);
   assign out_valid_o = (state != ST_EMPTY);
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   assign stalled     = out_valid_o & ~out_ready_i;
   assign occupancy_o = state;

   assign in_pay = {ctrl_i, s1_i, s2_i, v1_i, v2_i};
   assign {head_ctrl, s1_o, s2_o, v1_o, v2_o} = head_q;

   // An invalid stage must present an all-zero control bundle so that no enables leak downstream.
   assign ctrl_o = out_valid_o ? head_ctrl : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (stalled && (stall_cnt_o != {SW{1'b1}}))
            stall_cnt_o <= stall_cnt_o + 1'b1;

         if (flush_i) begin
            state <= ST_EMPTY;
         end else begin
            case (state)
               ST_EMPTY: begin
                  if (in_fire) begin
                     state  <= ST_ONE;
                     head_q <= in_pay;
                  end
               end
               ST_ONE: begin
                  if (in_fire && out_fire) begin
                     head_q <= in_pay;
                  end else if (in_fire) begin
                     state  <= ST_TWO;
                     skid_q <= in_pay;
                  end else if (out_fire) begin
                     state <= ST_EMPTY;
                  end
               end
               ST_TWO: begin
                  if (out_fire) begin
                     state  <= ST_ONE;
                     head_q <= skid_q;
                  end
               end
               default: state <= ST_EMPTY;
            endcase
         end
      end
   end

endmodule
